slot_alloc: RTL
===============

// Module: slot_alloc
// PURPOSE
//   Allocator stage directly upstream of slot_status in the optimized TX path.
//   - Accepts slot requests from the WQE fetch logic.
//   - Selects a free slot round-robin from the status vector.
//   - Returns a grant to the requester over a valid/ready handshake.
//   - Issues the set/reset pulses that slot_status consumes.
//   - Registers slot release requests and forwards them as reset pulses.
// PARAMETERS
//   SLOT_NUM         4   number of slots tracked; must equal slot_status SLOT_NUM
//   SLOT_ADDR_WIDTH  2   log2(SLOT_NUM), slot index width
// PORTS
//   clk              in   1      clock
//   rst_n            in   1      asynchronous, active-low reset
//   i_alloc_req      in   1      upstream requests one slot
//   o_alloc_ready    out  1      request accepted this cycle when high with i_alloc_req
//   o_grant_valid    out  1      grant register holds a slot index
//   o_grant_slot     out  W      granted slot index (W = SLOT_ADDR_WIDTH)
//   i_grant_ready    in   1      consumer takes the grant this cycle
//   i_free_req       in   1      release request
//   i_free_addr      in   W      slot to release
//   i_slot_status    in   N      busy vector from slot_status (N = SLOT_NUM)
//   o_set_req        out  1      set pulse to slot_status
//   o_set_addr       out  W      slot to mark busy
//   o_reset_req      out  1      reset pulse to slot_status
//   o_reset_addr     out  W      slot to mark free
//   o_free_cnt       out  W+1    count of allocatable slots
//   o_full           out  1      o_free_cnt == 0
//   o_err_dbl_free   out  1      sticky: release of a non-busy slot
// BEHAVIOUR
//   Reset values: all outputs 0 except o_free_cnt = SLOT_NUM; rr_ptr = 0; state = IDLE.
//   Effective busy
//     - eff_busy = i_slot_status | (o_set_req ? onehot(o_set_addr) : 0).
//     - Covers the one-cycle lag before slot_status reflects a set, so no slot
//       is double-granted back-to-back.
//   Free count and ready (combinational)
//     - o_free_cnt = popcount(~eff_busy); o_full = (o_free_cnt == 0).
//     - o_alloc_ready = !o_full && (state == IDLE || i_grant_ready).
//   Picker
//     - First clear bit of eff_busy, scanning from rr_ptr upward with wrap to 0.
//   Accept (i_alloc_req && o_alloc_ready) at cycle t; at t+1:
//     - o_grant_valid = 1 and o_grant_slot = pick.
//     - o_set_req = 1 and o_set_addr = pick. o_set_req is a single-cycle pulse.
//     - rr_ptr = (pick + 1) mod SLOT_NUM.
//   FSM
//     - IDLE -> GRANT on accept.
//     - GRANT -> IDLE on i_grant_ready without a new accept.
//     - GRANT -> GRANT on i_grant_ready with a new accept; this is back-to-back,
//       with no bubble.
//     - While in GRANT with !i_grant_ready: o_grant_slot is held stable and
//       o_alloc_ready = 0.
//   Release
//     - Registered: i_free_req at t with i_slot_status[i_free_addr] = 1 gives
//       o_reset_req = 1 (one-cycle pulse) and o_reset_addr = i_free_addr at t+1.
//     - Release of a non-busy slot: no reset pulse is issued and o_err_dbl_free
//       is set; it clears only on reset.
//   Simultaneous events
//     - Accept and release in the same cycle are independent.
//     - A slot whose release is in flight stays busy in eff_busy until
//       slot_status clears it, so it is never re-granted before it is free.
//   Reset mid-operation
//     - Any pending grant and any set/reset pulse is dropped.
//     - The downstream slot_status is reset by the same rst_n.
// STRUCTURE
//   - Shared package slot_pkg: SLOT_NUM, SLOT_ADDR_WIDTH, FSM state encoding (IDLE, GRANT).
//   - One sub-module, slot_rr_pick: combinational round-robin first-free picker.
//     Inputs: busy vector, rr_ptr. Outputs: pick index, found flag.
// TESTING (bench closes the loop through a real slot_status instance)
//   1 Reset release: o_free_cnt = 4, o_alloc_ready = 1, all pulses 0, err 0.
//   2 Req held 5 cycles, i_grant_ready = 1: grants 0,1,2,3 on consecutive cycles,
//     one o_set_req per grant; 5th request stalls with o_full = 1.
//   3 i_grant_ready = 0 for 3 cycles after a grant of slot 0: grant valid and slot
//     held; o_set_req pulses exactly once; o_alloc_ready = 0 until the grant is taken.
//   4 All slots full, free slot 2: o_reset_req with addr 2 the next cycle; ready
//     rises the cycle after; next grant is slot 2.
//   5 Free idle slot 1: no o_reset_req; o_err_dbl_free = 1 and stays 1 until rst_n.
//   6 rst_n asserted while o_grant_valid = 1: outputs return to reset values;
//     first grant after release is slot 0.

Source files
------------

// File: rtl/slot_alloc_pkg.sv
// Shared constants and FSM encoding for the slot allocator.
// Revision: 1.0
`default_nettype none

package slot_pkg;
  localparam int SLOT_NUM        = 4;
  localparam int SLOT_ADDR_WIDTH = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/slot_alloc_if.sv
// Request/grant, release and slot_status signals of the slot allocator.
// Revision: 1.0
`default_nettype none

interface slot_alloc_if;
  import slot_pkg::*;

  logic                       i_alloc_req;
  logic                       o_alloc_ready;
  logic                       o_grant_valid;
  logic [SLOT_ADDR_WIDTH-1:0] o_grant_slot;
  logic                       i_grant_ready;
  logic                       i_free_req;
  logic [SLOT_ADDR_WIDTH-1:0] i_free_addr;
  logic [SLOT_NUM-1:0]        i_slot_status;
  logic                       o_set_req;
  logic [SLOT_ADDR_WIDTH-1:0] o_set_addr;
  logic                       o_reset_req;
  logic [SLOT_ADDR_WIDTH-1:0] o_reset_addr;
  logic [SLOT_ADDR_WIDTH:0]   o_free_cnt;
  logic                       o_full;
  logic                       o_err_dbl_free;

  modport master (
    output i_alloc_req, i_grant_ready, i_free_req, i_free_addr, i_slot_status,
    input  o_alloc_ready, o_grant_valid, o_grant_slot, o_set_req, o_set_addr,
           o_reset_req, o_reset_addr, o_free_cnt, o_full, o_err_dbl_free
  );

  modport slave (
    input  i_alloc_req, i_grant_ready, i_free_req, i_free_addr, i_slot_status,
    output o_alloc_ready, o_grant_valid, o_grant_slot, o_set_req, o_set_addr,
           o_reset_req, o_reset_addr, o_free_cnt, o_full, o_err_dbl_free
  );
endinterface

`default_nettype wire

// File: rtl/slot_alloc_rr_pick.sv
// Combinational round-robin first-free slot picker, scanning upward from rr_ptr.
// Revision: 1.0
`default_nettype none

module slot_rr_pick
  import slot_pkg::*;
(
  input  logic [SLOT_NUM-1:0]        busy_i,
  input  logic [SLOT_ADDR_WIDTH-1:0] rr_ptr_i,
  output logic [SLOT_ADDR_WIDTH-1:0] pick_o,
  output logic                       found_o
);

  logic [SLOT_ADDR_WIDTH-1:0] idx;

  // SLOT_NUM is a power of two, so the index wraps naturally.
  always_comb begin
    pick_o  = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < SLOT_NUM; k++) begin
      idx = rr_ptr_i + SLOT_ADDR_WIDTH'(k);
      if (!found_o && !busy_i[idx]) begin
        found_o = 1'b1;
        pick_o  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/slot_alloc.sv
// Slot allocator: round-robin grant of free slots and set/reset pulses to slot_status.
// Revision: 1.0
`default_nettype none

module slot_alloc
  import slot_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  slot_alloc_if.slave  bus
);

  state_e                     state_q, state_d;
  logic [SLOT_ADDR_WIDTH-1:0] rr_ptr_q, grant_slot_q, set_addr_q, reset_addr_q;
  logic                       set_req_q, reset_req_q, err_q;
  logic [SLOT_ADDR_WIDTH-1:0] pick;
  logic                       found, ready, accept, grant_valid;
  logic                       rel_ok, rel_bad;
  logic [SLOT_NUM-1:0]        eff_busy;
  logic [SLOT_ADDR_WIDTH:0]   free_cnt;

  // A set issued last cycle is not yet visible in slot_status.
  always_comb begin
    eff_busy = bus.i_slot_status;
    if (set_req_q) eff_busy[set_addr_q] = 1'b1;
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < SLOT_NUM; i++)
      free_cnt = free_cnt + (SLOT_ADDR_WIDTH+1)'(!eff_busy[i]);
  end

  assign ready   = (free_cnt != '0) && (state_q == IDLE || bus.i_grant_ready);
  assign accept  = bus.i_alloc_req && ready && found;
  assign rel_ok  = bus.i_free_req &&  bus.i_slot_status[bus.i_free_addr];
  assign rel_bad = bus.i_free_req && !bus.i_slot_status[bus.i_free_addr];

  slot_rr_pick u_pick (
    .busy_i   (eff_busy),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .found_o  (found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = GRANT;
      GRANT:   if (bus.i_grant_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_valid = (state_q == GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      grant_slot_q <= '0;
      set_req_q    <= 1'b0;
      set_addr_q   <= '0;
      reset_req_q  <= 1'b0;
      reset_addr_q <= '0;
      err_q        <= 1'b0;
    end else begin
      set_req_q   <= accept;
      reset_req_q <= rel_ok;
      if (accept) begin
        grant_slot_q <= pick;
        set_addr_q   <= pick;
        rr_ptr_q     <= pick + SLOT_ADDR_WIDTH'(1);
      end
      if (rel_ok)  reset_addr_q <= bus.i_free_addr;
      if (rel_bad) err_q        <= 1'b1;
    end
  end

  assign bus.o_alloc_ready  = ready;
  assign bus.o_grant_valid  = grant_valid;
  assign bus.o_grant_slot   = grant_slot_q;
  assign bus.o_set_req      = set_req_q;
  assign bus.o_set_addr     = set_addr_q;
  assign bus.o_reset_req    = reset_req_q;
  assign bus.o_reset_addr   = reset_addr_q;
  assign bus.o_free_cnt     = free_cnt;
  assign bus.o_full         = (free_cnt == '0);
  assign bus.o_err_dbl_free = err_q;

endmodule

`default_nettype wire
